// File: rtl/cpu_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : cpu_wb_arb
// Purpose  : Writeback-side arbiter for the regfile write port. MEM-stage
//            results always win; long-unit (mult/div) results are queued in
//            a DEPTH-entry FIFO and drain into cycles the MEM stage leaves
//            idle. A MEM write to register r invalidates any older queued
//            long-unit result for r, because the MEM instruction is younger.
//            Killed entries keep their FIFO slot and are discarded
//            (drop_pulse) when they reach the head.
// Ports    : clk, clr (async, active-high)
//            mem_write_en/num/data  - MEM-stage write request
//            lu_valid/num/data      - long-unit result, held until accepted
//            lu_ready               - FIFO can accept (registered state only)
//            reg_write_en/num/data  - registered regfile write port
//            pend_mask              - one bit per register with a live queued result
//            buf_count              - occupied FIFO slots
//            drop_pulse             - registered pulse, a stale result was discarded
// Options  : WB_BYPASS_EN - when the FIFO is empty and the MEM slot is free,
//            a long-unit result writes directly (1-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module cpu_wb_arb #(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      mem_write_en,
   input  logic [4:0]                mem_write_num,
   input  logic [31:0]               mem_write_data,
   input  logic                      lu_valid,
   input  logic [4:0]                lu_num,
   input  logic [31:0]               lu_data,
   output logic                      lu_ready,
   output logic                      reg_write_en,
   output logic [4:0]                reg_write_num,
   output logic [31:0]               reg_write_data,
   output logic [31:0]               pend_mask,
   output logic [$clog2(DEPTH):0]    buf_count,
   output logic                      drop_pulse
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

   // FIFO storage; r_vld doubles as the kill flag for each slot
   logic [4:0]       r_num  [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_count;

   logic             w_mem_busy;
   logic             w_accept;
   logic             w_empty;
   logic             w_pop;
   logic             w_head_vld;
   logic             w_lu_kill;
   logic             w_bypass;
   logic             w_push;
   logic [31:0]      w_pend;

   assign lu_ready   = (r_count < C_DEPTH);
   assign buf_count  = r_count;
   assign w_mem_busy = mem_write_en && (mem_write_num != 5'd0);
   assign w_accept   = lu_valid && lu_ready;
   assign w_empty    = (r_count == '0);
   assign w_head_vld = r_vld[r_rptr];
   // The head leaves the FIFO whenever MEM does not own the write slot,
   // whether it carries a live result or a killed one.
   assign w_pop      = !w_mem_busy && !w_empty;
   // Same-cycle collision: MEM is younger, so the incoming result is stale.
   // mem_write_num is nonzero here, so lu_num is nonzero too.
   assign w_lu_kill  = w_accept && w_mem_busy && (lu_num == mem_write_num);

`ifdef WB_BYPASS_EN
   assign w_bypass   = w_empty && !w_mem_busy && lu_valid && (lu_num != 5'd0);
`else
   assign w_bypass   = 1'b0;
`endif

   assign w_push     = w_accept && (lu_num != 5'd0) && !w_lu_kill && !w_bypass;

   // Slots outside the occupied range always have r_vld clear, so a plain
   // OR over every slot gives the pending mask. $0 is never pushed.
   always_comb begin
      w_pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i]) begin
            w_pend[r_num[i]] = 1'b1;
         end
      end
   end
   assign pend_mask = w_pend;

   // Control state and output registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_vld          <= '0;
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_count        <= '0;
         reg_write_en   <= 1'b0;
         reg_write_num  <= 5'd0;
         reg_write_data <= 32'd0;
         drop_pulse     <= 1'b0;
      end else begin
         // Kill older queued results for the register MEM is writing
         for (int i = 0; i < DEPTH; i++) begin
            if (w_mem_busy && (r_num[i] == mem_write_num)) begin
               r_vld[i] <= 1'b0;
            end
         end
         if (w_pop) begin
            r_vld[r_rptr] <= 1'b0;
            r_rptr        <= r_rptr + C_PTR_ONE;
         end
         // Push never targets the slot being popped: that would need full
         if (w_push) begin
            r_vld[r_wptr] <= 1'b1;
            r_wptr        <= r_wptr + C_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase

         drop_pulse <= w_lu_kill || (w_pop && !w_head_vld);

         if (w_mem_busy) begin
            reg_write_en   <= 1'b1;
            reg_write_num  <= mem_write_num;
            reg_write_data <= mem_write_data;
         end else if (w_bypass) begin
            reg_write_en   <= 1'b1;
            reg_write_num  <= lu_num;
            reg_write_data <= lu_data;
         end else if (w_pop && w_head_vld) begin
            reg_write_en   <= 1'b1;
            reg_write_num  <= r_num[r_rptr];
            reg_write_data <= r_data[r_rptr];
         end else begin
            reg_write_en   <= 1'b0;
         end
      end
   end

   // Payload storage needs no reset: r_vld gates every use of it
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_num[r_wptr]  <= lu_num;
         r_data[r_wptr] <= lu_data;
      end
   end

endmodule
`default_nettype wire
